// File: rtl/cdc_hs_pkg.sv
// Shared definitions for the req/ack CDC handshake pair (source and destination ends).
// State encoding is common to both ends so debug views decode identically.
package cdc_hs_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_REQ_HI = 2'd1;
  localparam logic [ST_W-1:0] ST_REQ_LO = 2'd2;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdc_ack_sync.sv
// Multi-flop synchroniser for the asynchronous ack level returning from the
// destination domain. Synchronous active-high reset clears every stage.
module cdc_ack_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source end of a four-phase req/ack CDC handshake: accepts a word on valid/ready,
// holds it on tx_data while tx_req is high, and waits for ack to return to zero.
// Optional REQ_HI timeout with sticky error flag: define CDC_TX_TIMEOUT_EN.
module cdc_hs_tx
  import cdc_hs_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk_src,
  input  logic              rst,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              tx_req,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ack_async,
  output logic              done,
  output logic              busy,
  output logic              err_timeout
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("cdc_hs_tx: SYNC_STAGES must be within 2..4");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("cdc_hs_tx: TIMEOUT_CYCLES must be at least 2");
  end

  logic              ack_s;
  logic [ST_W-1:0]   state;
  logic [ST_W-1:0]   state_nxt;
  logic              tx_req_nxt;
  logic [DATA_W-1:0] tx_data_nxt;
  logic              done_nxt;
  logic              busy_nxt;
  logic              accept;

  cdc_ack_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk_src),
    .rst (rst),
    .d   (tx_ack_async),
    .q   (ack_s)
  );

  // A stale high ack must clear before a new request may be launched.
  assign src_ready = (state == ST_IDLE) && !ack_s;
  assign accept    = src_valid && src_ready;

`ifdef CDC_TX_TIMEOUT_EN
  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             expired;
  logic             err_nxt;

  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_nxt   = state;
    tx_req_nxt  = tx_req;
    tx_data_nxt = tx_data;
    done_nxt    = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
    err_nxt     = err_timeout;
`endif
    case (state)
      ST_IDLE: begin
        if (accept) begin
          tx_data_nxt = src_data;
          tx_req_nxt  = 1'b1;
          state_nxt   = ST_REQ_HI;
        end
      end
      ST_REQ_HI: begin
        if (ack_s) begin
          tx_req_nxt = 1'b0;
          state_nxt  = ST_REQ_LO;
        end
`ifdef CDC_TX_TIMEOUT_EN
        else if (expired) begin
          tx_req_nxt = 1'b0;
          err_nxt    = 1'b1;
          state_nxt  = ST_REQ_LO;
        end
`endif
      end
      ST_REQ_LO: begin
        if (!ack_s) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        tx_req_nxt = 1'b0;
        state_nxt  = ST_IDLE;
      end
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk_src) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_src) begin
    if (rst) begin
      tx_req  <= 1'b0;
      tx_data <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      tx_req  <= tx_req_nxt;
      tx_data <= tx_data_nxt;
      done    <= done_nxt;
      busy    <= busy_nxt;
    end
  end

`ifdef CDC_TX_TIMEOUT_EN
  // Wait counter only advances while REQ_HI persists; any state change clears it.
  always_comb begin
    cnt_nxt = '0;
    if (state == ST_REQ_HI && state_nxt == ST_REQ_HI) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_src) begin
    if (rst) begin
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      err_timeout <= err_nxt;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Randomised bench for cdc_hs_tx with a behavioural destination responder on an
// unrelated 13 ns clock; expected words and latencies come from the handshake rules.
module tb_cdc_hs_tx;

  localparam int unsigned DW   = 8;
  localparam int unsigned SYNC = 2;
  localparam int unsigned TMO  = 16;

  logic          clk_src   = 1'b0;
  logic          clk_dst   = 1'b0;
  logic          rst       = 1'b1;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data  = '0;
  logic          src_ready;
  logic          tx_req;
  logic [DW-1:0] tx_data;
  logic          tx_ack_async;
  logic          done;
  logic          busy;
  logic          err_timeout;

  logic use_man = 1'b1;
  logic ack_man = 1'b0;
  logic rsp_ack = 1'b0;

  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;
  logic [DW-1:0] got_log[$];

  assign tx_ack_async = use_man ? ack_man : rsp_ack;

  cdc_hs_tx #(
    .DATA_W         (DW),
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_src      (clk_src),
    .rst          (rst),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .tx_req       (tx_req),
    .tx_data      (tx_data),
    .tx_ack_async (tx_ack_async),
    .done         (done),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  always #5 clk_src = ~clk_src;

  initial begin
    forever begin
      #7 clk_dst = 1'b1;
      #6 clk_dst = 1'b0;
    end
  end

  // Destination model: 2-flop req capture, logs the word, acks after a random
  // delay, and drops ack once it sees req low.
  initial begin : responder
    logic m1;
    logic m2;
    int   dly;
    m1  = 1'b0;
    m2  = 1'b0;
    dly = 0;
    forever begin
      @(posedge clk_dst);
      if (use_man) begin
        rsp_ack = 1'b0;
        dly     = 0;
      end else if (m2 && !rsp_ack) begin
        if (dly == 0) begin
          got_log.push_back(tx_data);
          rsp_ack = 1'b1;
          dly     = int'($urandom_range(3, 0));
        end else begin
          dly--;
        end
      end else if (!m2 && rsp_ack) begin
        rsp_ack = 1'b0;
      end
      m2 = m1;
      m1 = tx_req;
    end
  end

  always @(negedge clk_src) begin
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_stream(input int n, input bit rnd, input int max_gap);
    logic [DW-1:0] words[$];
    logic [DW-1:0] w;
    int base;
    int d0;
    int g;
    base = got_log.size();
    d0   = done_cnt;
    @(negedge clk_src);
    for (int i = 0; i < n; i++) begin
      w = rnd ? 8'($urandom) : 8'(i + 1);
      words.push_back(w);
      if (max_gap > 0) begin
        src_valid = 1'b0;
        repeat ($urandom_range(32'(max_gap), 0)) @(negedge clk_src);
      end
      src_valid = 1'b1;
      src_data  = w;
      g = 0;
      while (!src_ready && g < 1000) begin
        @(negedge clk_src);
        g++;
      end
      if (g >= 1000) begin
        check("stream_accept_wait", 32'(g), 32'(0));
        break;
      end
      @(negedge clk_src);
    end
    src_valid = 1'b0;
    g = 0;
    while ((done_cnt - d0) < n && g < 5000) begin
      @(negedge clk_src);
      g++;
    end
    repeat (8) @(negedge clk_src);
    check("stream_done_cnt", 32'(done_cnt - d0), 32'(n));
    check("stream_log_len", 32'(got_log.size() - base), 32'(n));
    for (int i = 0; i < n && (base + i) < got_log.size(); i++) begin
      check($sformatf("stream_word%0d", i), 32'(got_log[base + i]), 32'(words[i]));
    end
  endtask

  initial begin
    int   n;
    int   d0;
    int   base;
    logic saw_ready;
    logic saw_req;
    logic saw_bad;

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk_src);
    @(negedge clk_src);
    check("rst_tx_req", 32'(tx_req), 32'(0));
    check("rst_tx_data", 32'(tx_data), 32'(0));
    check("rst_src_ready", 32'(src_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err_timeout), 32'(0));
    rst = 1'b0;

    // Single transfer with hand-driven ack for exact edge counts
    @(negedge clk_src);
    src_valid = 1'b1;
    src_data  = 8'hA5;
    check("t2_ready", 32'(src_ready), 32'(1));
    @(posedge clk_src);
    #1;
    check("t2_req_rise", 32'(tx_req), 32'(1));
    check("t2_data", 32'(tx_data), 32'hA5);
    check("t2_busy", 32'(busy), 32'(1));
    check("t2_ready_low", 32'(src_ready), 32'(0));
    src_valid = 1'b0;
    repeat (2) @(negedge clk_src);
    check("t2_req_hold", 32'(tx_req), 32'(1));
    ack_man = 1'b1;
    n = 0;
    do begin
      @(posedge clk_src);
      #1;
      n++;
    end while (tx_req && n < 20);
    check("t2_req_fall_edges", 32'(n), 32'(SYNC + 1));
    check("t2_data_after_fall", 32'(tx_data), 32'hA5);
    @(negedge clk_src);
    ack_man = 1'b0;
    d0      = done_cnt;
    n       = 0;
    saw_bad = 1'b0;
    do begin
      @(posedge clk_src);
      #1;
      n++;
      if (tx_data !== 8'hA5) saw_bad = 1'b1;
    end while (!done && n < 20);
    check("t2_done_edges", 32'(n), 32'(SYNC + 1));
    check("t2_data_until_done", 32'(saw_bad), 32'(0));
    @(posedge clk_src);
    #1;
    check("t2_done_single", 32'(done), 32'(0));
    check("t2_busy_idle", 32'(busy), 32'(0));
    check("t2_done_count", 32'(done_cnt - d0), 32'(1));

    // Back-to-back stream, then randomised words and gaps
    use_man = 1'b0;
    run_stream(16, 1'b0, 0);
    run_stream(24, 1'b1, 3);

    // Stale ack out of reset
    @(negedge clk_src);
    use_man = 1'b1;
    ack_man = 1'b1;
    rst     = 1'b1;
    repeat (3) @(negedge clk_src);
    rst = 1'b0;
    repeat (3) @(negedge clk_src);
    src_valid = 1'b1;
    src_data  = 8'h5A;
    saw_ready = 1'b0;
    saw_req   = 1'b0;
    repeat (8) begin
      @(negedge clk_src);
      if (src_ready) saw_ready = 1'b1;
      if (tx_req) saw_req = 1'b1;
    end
    check("t4_ready_blocked", 32'(saw_ready), 32'(0));
    check("t4_no_req", 32'(saw_req), 32'(0));
    ack_man = 1'b0;
    n = 0;
    do begin
      @(posedge clk_src);
      #1;
      n++;
    end while (!tx_req && n < 20);
    check("t4_req_after_release", 32'(n), 32'(SYNC + 1));
    check("t4_data", 32'(tx_data), 32'h5A);
    src_valid = 1'b0;
    d0      = done_cnt;
    base    = got_log.size();
    use_man = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 500) begin
      @(negedge clk_src);
      n++;
    end
    check("t4_done", 32'(done_cnt - d0), 32'(1));
    check("t4_log_len", 32'(got_log.size() - base), 32'(1));
    if (got_log.size() > base) check("t4_log_word", 32'(got_log[base]), 32'h5A);

    // Reset while REQ_HI
    repeat (2) @(negedge clk_src);
    use_man = 1'b1;
    ack_man = 1'b0;
    repeat (4) @(negedge clk_src);
    src_valid = 1'b1;
    src_data  = 8'($urandom);
    n = 0;
    while (!src_ready && n < 50) begin
      @(negedge clk_src);
      n++;
    end
    @(posedge clk_src);
    #1;
    check("t5_req_rise", 32'(tx_req), 32'(1));
    src_valid = 1'b0;
    repeat (2) @(posedge clk_src);
    @(negedge clk_src);
    rst = 1'b1;
    d0  = done_cnt;
    @(posedge clk_src);
    #1;
    check("t5_req_abort", 32'(tx_req), 32'(0));
    check("t5_busy", 32'(busy), 32'(0));
    check("t5_data_clr", 32'(tx_data), 32'(0));
    check("t5_ready", 32'(src_ready), 32'(1));
    @(negedge clk_src);
    rst = 1'b0;
    repeat (6) @(negedge clk_src);
    check("t5_no_done", 32'(done_cnt - d0), 32'(0));

`ifdef CDC_TX_TIMEOUT_EN
    // Silent destination: REQ_HI times out and the error flag sticks
    src_valid = 1'b1;
    src_data  = 8'h3C;
    n = 0;
    while (!src_ready && n < 50) begin
      @(negedge clk_src);
      n++;
    end
    @(posedge clk_src);
    #1;
    check("t6_req_rise", 32'(tx_req), 32'(1));
    src_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk_src);
      #1;
      n++;
    end while (tx_req && n < 100);
    check("t6_timeout_edges", 32'(n), 32'(TMO));
    check("t6_err_set", 32'(err_timeout), 32'(1));
    @(posedge clk_src);
    #1;
    check("t6_done_after_timeout", 32'(done), 32'(1));
    use_man = 1'b0;
    run_stream(2, 1'b1, 0);
    check("t6_err_sticky", 32'(err_timeout), 32'(1));
`else
    use_man = 1'b0;
    run_stream(2, 1'b1, 0);
    check("t6_err_tied_low", 32'(err_timeout), 32'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
